load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: converts core load/store requests (byte, halfword, word; signed/unsigned) into word-wide read/write cycles on a single-port data memory.
- Data memory: combinational read, write on posedge clk when write enable is high.
- Sub-word stores use read-modify-write.
- Sits between the MEM pipeline stage and the data memory. Uses a valid/ready request handshake and a valid/ready response handshake.

---
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts core load/store requests (byte, half, word; signed or unsigned)
//   into word-wide cycles on a single-port data memory with combinational
//   read and posedge write. Sub-word stores use read-modify-write.
//
//   Build option: LSU_ALIGN_CHECK_EN
//     defined   - misaligned half/word and size=11 accesses raise resp_err
//     undefined - low address bits are masked to natural alignment, size=11
//                 acts as word, and only the out-of-range check raises resp_err
//
//   Ports
//     clk, reset                  clock, synchronous active-high reset
//     req_valid/req_ready         request handshake
//     req_write, req_size,
//     req_signed, req_addr,
//     req_wdata                   request payload (byte address, right-aligned data)
//     resp_valid/resp_ready       response handshake
//     resp_rdata, resp_err        load result (zero for stores), error flag
//     mem_address, mem_write_data,
//     mem_write, mem_read,
//     mem_read_data               data-memory side

module load_store_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int MEMORY_DEPTH = 1024,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } stateType;

   stateType state, nextState;

   // Latched request
   logic                  writeQ;
   logic [1:0]            sizeQ;
   logic                  signedQ;
   logic [1:0]            lowQ;
   logic [DATA_WIDTH-1:0] wdataQ;
   logic [ADDR_WIDTH-1:0] memAddrQ;
   logic [DATA_WIDTH-1:0] capturedQ;
   logic [DATA_WIDTH-1:0] respRdataQ;
   logic                  respErrQ;

   // Request decode
   logic [1:0]            sizeEff;
   logic [1:0]            lowEff;
   logic                  alignErr;
   logic                  rangeErr;
   logic                  accessErr;

   logic [7:0]            byteLane;
   logic [15:0]           halfLane;
   logic [DATA_WIDTH-1:0] loadData;
   logic [DATA_WIDTH-1:0] mergeData;

   always_comb begin
      sizeEff  = req_size;
      lowEff   = req_addr[1:0];
      alignErr = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      case (req_size)
         2'b01:   alignErr = req_addr[0];
         2'b10:   alignErr = |req_addr[1:0];
         2'b11:   alignErr = 1'b1;
         default: alignErr = 1'b0;
      endcase
`else
      if (req_size == 2'b11) begin
         sizeEff = 2'b10;
      end
      case (sizeEff)
         2'b01:   lowEff[0] = 1'b0;
         2'b10:   lowEff    = '0;
         default: ;
      endcase
`endif
      rangeErr  = 32'(req_addr[31:2]) >= 32'(MEMORY_DEPTH);
      accessErr = alignErr | rangeErr;
   end

   // Load lane extraction and extension from the live read data
   always_comb begin
      byteLane = mem_read_data[{lowQ, 3'b000} +: 8];
      halfLane = mem_read_data[{lowQ[1], 4'b0000} +: 16];
      case (sizeQ)
         2'b00:   loadData = signedQ ? {{(DATA_WIDTH-8){byteLane[7]}}, byteLane}
                                     : {{(DATA_WIDTH-8){1'b0}}, byteLane};
         2'b01:   loadData = signedQ ? {{(DATA_WIDTH-16){halfLane[15]}}, halfLane}
                                     : {{(DATA_WIDTH-16){1'b0}}, halfLane};
         default: loadData = mem_read_data;
      endcase
   end

   // Store word: full word replaces, sub-word patches the captured word
   always_comb begin
      mergeData = capturedQ;
      case (sizeQ)
         2'b00:   mergeData[{lowQ, 3'b000} +: 8]     = wdataQ[7:0];
         2'b01:   mergeData[{lowQ[1], 4'b0000} +: 16] = wdataQ[15:0];
         default: mergeData = wdataQ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (accessErr) begin
                  nextState = RESP;
               end else if (req_write && (sizeEff == 2'b10)) begin
                  nextState = WR;
               end else begin
                  nextState = RD;
               end
            end
         end
         RD:      nextState = writeQ ? WR : RESP;
         WR:      nextState = RESP;
         RESP:    nextState = resp_ready ? IDLE : RESP;
         default: nextState = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = '0;
      case (state)
         IDLE: req_ready = 1'b1;
         RD:   mem_read  = 1'b1;
         WR: begin
            mem_write      = 1'b1;
            mem_write_data = mergeData;
         end
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request latch, read capture and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         writeQ     <= 1'b0;
         sizeQ      <= '0;
         signedQ    <= 1'b0;
         lowQ       <= '0;
         wdataQ     <= '0;
         memAddrQ   <= '0;
         capturedQ  <= '0;
         respRdataQ <= '0;
         respErrQ   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  writeQ     <= req_write;
                  sizeQ      <= sizeEff;
                  signedQ    <= req_signed;
                  lowQ       <= lowEff;
                  wdataQ     <= req_wdata;
                  memAddrQ   <= req_addr[ADDR_WIDTH+1:2];
                  respRdataQ <= '0;
                  respErrQ   <= accessErr;
               end
            end
            RD: begin
               capturedQ <= mem_read_data;
               if (!writeQ) begin
                  respRdataQ <= loadData;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_address = memAddrQ;
   assign resp_rdata  = respRdataQ;
   assign resp_err    = respErrQ;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [9:0]  mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_read_data;

   load_store_unit #(
      .DATA_WIDTH  (32),
      .MEMORY_DEPTH(1024),
      .ADDR_WIDTH  (10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_size      (req_size),
      .req_signed    (req_signed),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_write     (mem_write),
      .mem_read      (mem_read),
      .mem_read_data (mem_read_data)
   );

   always #5 clk = ~clk;

   // Data memory model: combinational read, posedge write
   logic [31:0] memModel [0:1023];
   assign mem_read_data = memModel[mem_address];
   always @(posedge clk) begin
      if (mem_write) memModel[mem_address] <= mem_write_data;
   end

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } expT;

   expT sbQ[$];
   int  checks = 0;
   int  errors = 0;

   int          wrCount, rdCount, bothCount;
   logic [31:0] lastWrData;
   logic [9:0]  lastWrAddr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory-side monitor
   always @(negedge clk) begin
      if (mem_write) begin
         wrCount++;
         lastWrData = mem_write_data;
         lastWrAddr = mem_address;
      end
      if (mem_read) rdCount++;
      if (mem_read && mem_write) bothCount++;
   end

   // Response monitor: pops the scoreboard on each handshake
   always @(negedge clk) begin
      if (!reset && resp_valid && resp_ready) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got %h/%b expected none", resp_rdata, resp_err);
         end else begin
            expT e;
            e = sbQ.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
         end
      end
   end

   // Issue one request and follow it to completion; called at posedge+1 while idle
   task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expRdata, input logic expErr, input int expLat,
                        input int expRd, input int expWr, input logic [9:0] expWrAddr,
                        input logic [31:0] expWrData, input int holdCycles);
      int lat;
      int n;
      wrCount = 0; rdCount = 0; bothCount = 0;
      sbQ.push_back('{expRdata, expErr});
      resp_ready = (holdCycles == 0);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, lat, expLat);
      for (int i = 0; i < holdCycles; i++) begin
         check({name, "_hold_flags"}, {29'b0, resp_valid, resp_err, req_ready},
               {29'b0, 1'b1, expErr, 1'b0});
         check({name, "_hold_rdata"}, resp_rdata, expRdata);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got busy expected idle", name);
      end
      check({name, "_reads"}, rdCount, expRd);
      check({name, "_writes"}, wrCount, expWr);
      check({name, "_overlap"}, bothCount, 0);
      if (expWr > 0) begin
         check({name, "_wr_addr"}, {22'b0, lastWrAddr}, {22'b0, expWrAddr});
         check({name, "_wr_data"}, lastWrData, expWrData);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) memModel[i] = 32'h0;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
      check("rst_mem_address", {22'b0, mem_address}, 32'd0);
      check("rst_mem_wdata", mem_write_data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // name wr sz sg addr wdata | rdata err lat rd wr wraddr wrdata hold
      issue("st_word", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 10'd4, 32'hDEADBEEF, 0);
      issue("ld_word", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 10'd0, 32'h0, 0);

      memModel[4] = 32'h11223344;
      issue("ld_sb_13", 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000011, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      memModel[4] = 32'h1122F344;
      issue("ld_sb_11", 0, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFFF3, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_ub_11", 0, 2'b00, 0, 32'h11, 32'h0, 32'h000000F3, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_sb_12", 0, 2'b00, 1, 32'h12, 32'h0, 32'h00000022, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_uh_12", 0, 2'b01, 0, 32'h12, 32'h0, 32'h00001122, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_sh_10", 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFF344, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_sw_10", 0, 2'b10, 1, 32'h10, 32'h0, 32'h1122F344, 0, 2, 1, 0, 10'd0, 32'h0, 0);

      memModel[4] = 32'h11223344;
      issue("st_byte", 1, 2'b00, 0, 32'h11, 32'hFFFFFFAA, 32'h0, 0, 3, 1, 1, 10'd4, 32'h1122AA44, 0);
      issue("st_half", 1, 2'b01, 0, 32'h12, 32'h1234BEEF, 32'h0, 0, 3, 1, 1, 10'd4, 32'hBEEFAA44, 0);
      issue("ld_after_st", 0, 2'b10, 0, 32'h10, 32'h0, 32'hBEEFAA44, 0, 2, 1, 0, 10'd0, 32'h0, 0);

`ifdef LSU_ALIGN_CHECK_EN
      issue("ld_mis_half", 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1, 0, 0, 10'd0, 32'h0, 0);
      issue("ld_mis_word", 0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0, 10'd0, 32'h0, 0);
      issue("ld_size11", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 10'd0, 32'h0, 0);
      issue("st_mis_word", 1, 2'b10, 0, 32'h12, 32'h55555555, 32'h0, 1, 1, 0, 0, 10'd0, 32'h0, 0);
`else
      issue("ld_mis_half", 0, 2'b01, 0, 32'h11, 32'h0, 32'h0000AA44, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_mis_word", 0, 2'b10, 0, 32'h13, 32'h0, 32'hBEEFAA44, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_size11", 0, 2'b11, 0, 32'h10, 32'h0, 32'hBEEFAA44, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("st_mis_word", 1, 2'b10, 0, 32'h22, 32'h55555555, 32'h0, 0, 2, 0, 1, 10'd8, 32'h55555555, 0);
`endif

      memModel[1023] = 32'hCAFEF00D;
      issue("ld_last_word", 0, 2'b10, 0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 2, 1, 0, 10'd0, 32'h0, 0);
      issue("ld_range", 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 0, 0, 10'd0, 32'h0, 5);
      issue("st_range", 1, 2'b00, 0, 32'hFFFFFFF1, 32'h77, 32'h0, 1, 1, 0, 0, 10'd0, 32'h0, 0);

      // Reset during the read phase of a byte store
      memModel[9] = 32'h55667788;
      wrCount = 0;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h25; req_wdata = 32'h000000EE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rmw_in_rd", {31'b0, mem_read}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rmw_rst_flags", {29'b0, req_ready, resp_valid, mem_write}, {29'b0, 3'b100});
      check("rmw_rst_addr", {22'b0, mem_address}, 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rmw_rst_writes", wrCount, 0);
      check("rmw_rst_mem", memModel[9], 32'h55667788);
      check("rmw_rst_idle", {30'b0, req_ready, resp_valid}, {30'b0, 2'b10});

      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d expected 0", sbQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
